// File: rtl/csr_access_arbiter.sv
// Round-robin arbiter sharing the single CSR-file access port between the commit-path
// CSR unit (requester 0) and the debug/hart-control port (requester 1).
module csr_access_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_ni,
  input  logic        r0_valid_i,
  output logic        r0_ready_o,
  input  logic [11:0] r0_addr_i,
  input  logic [1:0]  r0_opcode_i,
  input  logic        r0_wr_en_i,
  input  logic [31:0] r0_data_i,
  input  logic        r1_valid_i,
  output logic        r1_ready_o,
  input  logic [11:0] r1_addr_i,
  input  logic [1:0]  r1_opcode_i,
  input  logic        r1_wr_en_i,
  input  logic [31:0] r1_data_i,
  input  logic        trap_busy_i,
  output logic        csr_valid_o,
  output logic [11:0] csr_addr_o,
  output logic [1:0]  csr_opcode_o,
  output logic        csr_wr_en_o,
  output logic [31:0] csr_data_o,
  input  logic        csr_done_i,
  input  logic        csr_excp_i,
  input  logic [31:0] csr_data_i,
  output logic        rsp_valid_o,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_excp_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q;
  logic        rr_ptr_q;
  logic [7:0]  tmo_cnt_q;
  logic        id_q;
  logic [11:0] addr_q;
  logic [1:0]  opcode_q;
  logic        wr_en_q;
  logic [31:0] data_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_data_q;
  logic        rsp_excp_q;

  logic        grant_any;
  logic        grant_id;
  logic        tmo_hit;

  // On a tie the pointer picks; otherwise the lone requester wins.
  assign grant_any = (state_q == ST_IDLE) && (r0_valid_i || r1_valid_i);
  assign grant_id  = (r0_valid_i && r1_valid_i) ? rr_ptr_q : r1_valid_i;
  assign tmo_hit   = (tmo_cnt_q + 8'd1) == TMO_LAST;

  assign r0_ready_o   = grant_any && !grant_id;
  assign r1_ready_o   = grant_any &&  grant_id;
  // A trap update owns the CSR file this cycle, so the pending op waits behind it.
  assign csr_valid_o  = (state_q == ST_ISSUE) && !trap_busy_i;
  assign csr_addr_o   = addr_q;
  assign csr_opcode_o = opcode_q;
  assign csr_wr_en_o  = wr_en_q;
  assign csr_data_o   = data_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_excp_o   = rsp_excp_q;
  assign busy_o       = (state_q != ST_IDLE);

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
    if (!cpu_reset_ni) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      tmo_cnt_q   <= 8'd0;
      id_q        <= 1'b0;
      addr_q      <= 12'd0;
      opcode_q    <= 2'd0;
      wr_en_q     <= 1'b0;
      data_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_excp_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            id_q     <= grant_id;
            addr_q   <= grant_id ? r1_addr_i   : r0_addr_i;
            opcode_q <= grant_id ? r1_opcode_i : r0_opcode_i;
            wr_en_q  <= grant_id ? r1_wr_en_i  : r0_wr_en_i;
            data_q   <= grant_id ? r1_data_i   : r0_data_i;
            rr_ptr_q <= ~grant_id;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!trap_busy_i) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (csr_done_i) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_data_q  <= csr_data_i;
            rsp_excp_q  <= csr_excp_i;
            tmo_cnt_q   <= 8'd0;
            state_q     <= ST_IDLE;
          end else if (tmo_hit) begin
            // No completion from the CSR file: fail the op back to its owner.
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_data_q  <= 32'd0;
            rsp_excp_q  <= 1'b1;
            tmo_cnt_q   <= 8'd0;
            state_q     <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        default: begin
          tmo_cnt_q <= 8'd0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter: a transaction-level model checked every cycle,
// plus literal expectations on grant order, latency, timeout and reset behaviour.
module tb_csr_access_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [11:0] r0_addr = '0, r1_addr = '0;
  logic [1:0]  r0_op = '0, r1_op = '0;
  logic        r0_we = 1'b0, r1_we = 1'b0;
  logic [31:0] r0_data = '0, r1_data = '0;
  logic        trap_busy = 1'b0;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        csr_done = 1'b0, csr_excp = 1'b0;
  logic [31:0] csr_rdata = '0;
  logic        rsp_valid, rsp_id, rsp_excp, busy;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  csr_access_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .cpu_clock_i(clk), .cpu_reset_ni(rst_n),
    .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_addr_i(r0_addr),
    .r0_opcode_i(r0_op), .r0_wr_en_i(r0_we), .r0_data_i(r0_data),
    .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_addr_i(r1_addr),
    .r1_opcode_i(r1_op), .r1_wr_en_i(r1_we), .r1_data_i(r1_data),
    .trap_busy_i(trap_busy),
    .csr_valid_o(csr_valid), .csr_addr_o(csr_addr), .csr_opcode_o(csr_op),
    .csr_wr_en_o(csr_we), .csr_data_o(csr_wdata),
    .csr_done_i(csr_done), .csr_excp_i(csr_excp), .csr_data_i(csr_rdata),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .rsp_excp_o(rsp_excp), .busy_o(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // CSR-file responder: completes one cycle after each issue when enabled.
  bit          rsp_en = 1'b1;
  bit          rsp_excp_cfg = 1'b0;
  logic [31:0] rsp_data_cfg = '0;
  bit          stray_done = 1'b0;

  always begin
    bit go;
    @(negedge clk);
    go = csr_valid && rsp_en;
    @(posedge clk);
    #2;
    csr_done  = go || stray_done;
    csr_excp  = go ? rsp_excp_cfg : 1'b0;
    csr_rdata = go ? rsp_data_cfg : 32'd0;
  end

  // Transaction-level model: an op is owned from accept until its response; it is
  // issued on the first owned cycle free of trap_busy, and completes on done or at
  // the deadline TMO cycles after the issue pulse.
  int          cyc = 0;
  bit          m_busy, m_issued, m_id, m_rr;
  int          m_issue_cyc;
  logic [11:0] m_addr;
  logic [1:0]  m_op;
  logic        m_we;
  logic [31:0] m_data;
  bit          m_rsp_v, m_rsp_id, m_rsp_e;
  logic [31:0] m_rsp_d;

  int          accept_cyc, issue_cyc, rsp_cyc, rsp_count = 0;
  logic [11:0] iss_addr;
  logic [31:0] iss_data;
  bit          lr_id, lr_excp;
  logic [31:0] lr_data;
  bit          grants[$];
  bit          rsp_ids[$];

  always @(negedge clk) begin
    bit e_g0, e_g1, e_iss;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_issued = 0; m_id = 0; m_rr = 0; m_issue_cyc = 0;
      m_addr = '0; m_op = '0; m_we = 0; m_data = '0;
      m_rsp_v = 0; m_rsp_id = 0; m_rsp_e = 0; m_rsp_d = '0;
      chk("rst_outputs", {r0_ready, r1_ready, csr_valid, csr_addr, csr_op, csr_we,
                          rsp_valid, rsp_id, rsp_excp, busy}, 64'd0);
      chk("rst_data", {csr_wdata, rsp_data}, 64'd0);
    end else begin
      e_g0  = !m_busy && r0_valid && (!r1_valid || !m_rr);
      e_g1  = !m_busy && r1_valid && (!r0_valid ||  m_rr);
      e_iss = m_busy && !m_issued && !trap_busy;
      chk("r0_ready", r0_ready, e_g0);
      chk("r1_ready", r1_ready, e_g1);
      chk("ready_exclusive", r0_ready && r1_ready, 1'b0);
      chk("csr_valid", csr_valid, e_iss);
      chk("payload", {csr_addr, csr_op, csr_we, csr_wdata}, {m_addr, m_op, m_we, m_data});
      chk("rsp_valid", rsp_valid, m_rsp_v);
      chk("rsp_fields", {rsp_id, rsp_excp, rsp_data}, {m_rsp_id, m_rsp_e, m_rsp_d});
      chk("busy", busy, m_busy);

      if (r0_ready || r1_ready) begin grants.push_back(r1_ready); accept_cyc = cyc; end
      if (csr_valid) begin issue_cyc = cyc; iss_addr = csr_addr; iss_data = csr_wdata; end
      if (rsp_valid) begin
        rsp_count++; rsp_cyc = cyc; rsp_ids.push_back(rsp_id);
        lr_id = rsp_id; lr_excp = rsp_excp; lr_data = rsp_data;
      end

      m_rsp_v = 0;
      if (!m_busy) begin
        if (e_g0 || e_g1) begin
          m_busy = 1; m_issued = 0; m_id = e_g1; m_rr = !e_g1;
          m_addr = e_g1 ? r1_addr : r0_addr;
          m_op   = e_g1 ? r1_op   : r0_op;
          m_we   = e_g1 ? r1_we   : r0_we;
          m_data = e_g1 ? r1_data : r0_data;
        end
      end else if (!m_issued) begin
        if (!trap_busy) begin m_issued = 1; m_issue_cyc = cyc; end
      end else if (csr_done) begin
        m_rsp_v = 1; m_rsp_id = m_id; m_rsp_e = csr_excp; m_rsp_d = csr_rdata; m_busy = 0;
      end else if (cyc - m_issue_cyc == TMO - 1) begin
        m_rsp_v = 1; m_rsp_id = m_id; m_rsp_e = 1; m_rsp_d = 0; m_busy = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit id, input logic [11:0] a, input logic [1:0] op,
                     input bit we, input logic [31:0] d);
    bit got = 0;
    if (id) begin r1_valid = 1; r1_addr = a; r1_op = op; r1_we = we; r1_data = d; end
    else    begin r0_valid = 1; r0_addr = a; r0_op = op; r0_we = we; r0_data = d; end
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = id ? r1_ready : r0_ready;
    end
    step();
    r0_valid = 0; r1_valid = 0;
    if (!got) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input string nm);
    int c0 = rsp_count;
    for (int n = 0; n < 60; n++) begin
      step();
      if (rsp_count > c0) return;
    end
    chk(nm, 0, 1);
  endtask

  initial begin
    int ng, rc;
    bit who, got;
    #1 rst_n = 0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_csr_valid", csr_valid, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_payload", {csr_addr, csr_wdata}, 0);
    step(); step(); step();
    rst_n = 1;

    // Both requesters continuously valid from reset: grants alternate.
    rsp_data_cfg = 32'h1234_5678;
    r0_valid = 1; r0_addr = 12'h300; r0_op = 2'b01; r0_we = 1; r0_data = 32'hA0;
    r1_valid = 1; r1_addr = 12'h7B0; r1_op = 2'b10; r1_we = 1; r1_data = 32'hB1;
    ng = 0;
    for (int n = 0; n < 60 && ng < 4; n++) begin
      @(negedge clk);
      if (r0_ready || r1_ready) ng++;
    end
    step();
    r0_valid = 0; r1_valid = 0;
    for (int n = 0; n < 60 && rsp_ids.size() < 4; n++) step();
    chk("rr_grant_count", grants.size(), 4);
    chk("rr_grant0", grants[0], 0);
    chk("rr_grant1", grants[1], 1);
    chk("rr_grant2", grants[2], 0);
    chk("rr_grant3", grants[3], 1);
    chk("rr_rsp_count", rsp_ids.size(), 4);
    chk("rr_rsp_id0", rsp_ids[0], 0);
    chk("rr_rsp_id1", rsp_ids[1], 1);
    chk("rr_rsp_id3", rsp_ids[3], 1);

    // r0 alone, nominal three-cycle latency.
    rsp_data_cfg = 32'h0;
    req(0, 12'h340, 2'b01, 1, 32'hDEADBEEF);
    wait_rsp("lat_rsp_timeout");
    chk("lat_issue", issue_cyc - accept_cyc, 1);
    chk("lat_rsp", rsp_cyc - accept_cyc, 3);
    chk("lat_iss_addr", iss_addr, 12'h340);
    chk("lat_iss_data", iss_data, 32'hDEADBEEF);
    chk("lat_rsp_fields", {lr_id, lr_excp, lr_data}, 34'h0);

    // Trap busy for three cycles starting at the issue cycle.
    req(0, 12'h300, 2'b10, 1, 32'h0000_0088);
    trap_busy = 1;
    step(); step(); step();
    trap_busy = 0;
    wait_rsp("trap_rsp_timeout");
    chk("trap_issue_delay", issue_cyc - accept_cyc, 4);
    chk("trap_iss_addr", iss_addr, 12'h300);
    chk("trap_iss_data", iss_data, 32'h0000_0088);

    // No completion from the CSR file: timeout response.
    rsp_en = 0;
    req(1, 12'h305, 2'b10, 1, 32'h8);
    wait_rsp("tmo_rsp_missing");
    chk("tmo_delay", rsp_cyc - issue_cyc, TMO);
    chk("tmo_rsp", {lr_id, lr_excp, lr_data}, {1'b1, 1'b1, 32'h0});
    rsp_en = 1;
    rsp_data_cfg = 32'h55;
    req(0, 12'h341, 2'b01, 0, 32'h0);
    wait_rsp("post_tmo_rsp_timeout");
    chk("post_tmo_rsp", {lr_id, lr_excp, lr_data}, {1'b0, 1'b0, 32'h55});

    // A stray done while idle produces nothing.
    rc = rsp_count;
    stray_done = 1;
    step();
    stray_done = 0;
    step(); step(); step();
    chk("stray_done_ignored", rsp_count - rc, 0);

    // CSR file raises an exception for an r1 write, then r0 proceeds normally.
    rsp_excp_cfg = 1; rsp_data_cfg = 32'hBAD;
    req(1, 12'hF11, 2'b01, 1, 32'h0);
    wait_rsp("excp_rsp_timeout");
    chk("excp_rsp_id_excp", {lr_id, lr_excp}, 2'b11);
    rsp_excp_cfg = 0; rsp_data_cfg = 32'h42;
    req(0, 12'hF14, 2'b01, 0, 32'h0);
    wait_rsp("after_excp_rsp_timeout");
    chk("after_excp_rsp", {lr_id, lr_excp, lr_data}, {1'b0, 1'b0, 32'h42});

    // Reset during WAIT abandons the op.
    rsp_en = 0;
    req(1, 12'h7B1, 2'b01, 1, 32'h5);
    step(); step();
    chk("pre_reset_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_payload", {csr_addr, csr_wdata}, 0);
    step(); step();
    rst_n = 1;
    rsp_en = 1;
    rc = rsp_count;
    step(); step(); step(); step(); step();
    chk("no_rsp_after_reset", rsp_count - rc, 0);
    r0_valid = 1; r0_addr = 12'h300; r0_data = 32'h1;
    r1_valid = 1; r1_addr = 12'h7B0; r1_data = 32'h2;
    got = 0; who = 1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (r0_ready || r1_ready) begin got = 1; who = r1_ready; end
    end
    step();
    r0_valid = 0; r1_valid = 0;
    chk("rr_after_reset", {got, who}, 2'b10);
    wait_rsp("final_rsp_timeout");
    chk("final_rsp_id", lr_id, 0);

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/csr_access_arbiter.md
Name: csr_access_arbiter

Overview:
- Sequences and shares the single CSR-file access port between two requesters: requester 0 (core commit-path CSR unit) and requester 1 (debug/hart-control port).
- Arbitrates round-robin and drives one CSR operation at a time.
- Holds off issue while a trap/mret update is in flight.
- Returns read data and the exception flag with a requester ID, and converts a missing done into an exception response after a timeout.

Parameters:
- TIMEOUT_CYCLES, 8, number of WAIT cycles without csr_done_i before a forced exception response (min 2, max 255).

Ports:
cpu_clock_i  in  1  core clock
cpu_reset_ni  in  1  asynchronous active-low reset
r0_valid_i  in  1  requester 0 request
r0_ready_o  out  1  requester 0 accepted this cycle
r0_addr_i  in  12  requester 0 CSR address
r0_opcode_i  in  2  01 RW, 10 set, 11 clear
r0_wr_en_i  in  1  requester 0 write enable
r0_data_i  in  32  requester 0 operand
r1_valid_i, r1_ready_o, r1_addr_i, r1_opcode_i, r1_wr_en_i, r1_data_i  as r0, for requester 1
trap_busy_i  in  1  mret | take_exception | take_interrupt this cycle
csr_valid_o  out  1  CSR-file valid
csr_addr_o  out  12  CSR-file address
csr_opcode_o  out  2  CSR-file opcode
csr_wr_en_o  out  1  CSR-file write enable
csr_data_o  out  32  CSR-file operand
csr_done_i  in  1  CSR-file done
csr_excp_i  in  1  CSR-file exception
csr_data_i  in  32  CSR-file read data
rsp_valid_o  out  1  one-cycle response pulse
rsp_id_o  out  1  requester that owns the response
rsp_data_o  out  32  read data, or 0 on timeout
rsp_excp_o  out  1  exception flag
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, cpu_reset_ni low): state=IDLE, rr_ptr=0, timeout count=0.
  - All outputs 0 after reset, including the latched payload driven on csr_addr_o/csr_opcode_o/csr_wr_en_o/csr_data_o.
- Reset asserted mid-operation abandons the operation. No response is produced.
- States: IDLE, ISSUE, WAIT.
- IDLE: if either rX_valid_i is high, grant a requester (regardless of trap_busy_i).
  - Only one valid: grant it.
  - Both valid: grant rr_ptr.
  - Grant: rX_ready_o=1 combinationally in the same cycle, latch addr/opcode/wr_en/data/id, rr_ptr <= ~granted_id, next state ISSUE.
  - rX_ready_o is never high outside IDLE and never high for both requesters.
- ISSUE: csr_valid_o=1 only when trap_busy_i=0, then go to WAIT.
  - If trap_busy_i=1, stay in ISSUE with csr_valid_o=0. The CSR file gives traps priority and would drop the write.
  - csr_valid_o is high for exactly one cycle per operation. Payload outputs hold stable from ISSUE through end of WAIT.
- WAIT: the timeout counter increments each cycle.
  - On csr_done_i: register csr_data_i/csr_excp_i to rsp_data_o/rsp_excp_o, rsp_valid_o=1 next cycle with rsp_id_o=latched id, state=IDLE.
  - If count reaches TIMEOUT_CYCLES-1 without done: rsp_valid_o=1, rsp_excp_o=1, rsp_data_o=0, state=IDLE.
  - The counter clears on leaving WAIT.
  - csr_done_i outside WAIT is ignored.
- rsp_valid_o is a one-cycle pulse with no backpressure. rsp_data_o/rsp_excp_o/rsp_id_o hold until the next response.
- Latency, no trap: accept at T, csr_valid_o at T+1, csr_done_i at T+2, rsp_valid_o at T+3.
- The rsp_valid_o cycle is IDLE, so a new accept can occur in that same cycle. Peak throughput is one operation per 3 cycles.
- Write ordering: an operation accepted before a trap is issued after it. The CSR read value reflects post-trap state.

Test Plan:
- r0 only: addr 0x340, opcode 01, wr_en 1, data 0xDEADBEEF at T -> csr_valid_o at T+1 with the same payload; done with data 0x0 at T+2 -> rsp_valid_o at T+3, id 0, data 0, excp 0.
- r0 and r1 valid continuously from reset -> grants alternate 0,1,0,1. Each rsp_id_o matches its grant. ready_o never high for both.
- trap_busy_i high for 3 cycles starting at the ISSUE cycle -> csr_valid_o held 0 for 3 cycles, asserts on the 4th. Payload unchanged.
- csr_done_i never asserted, TIMEOUT_CYCLES=8 -> rsp_valid_o 8 cycles after the ISSUE pulse with excp=1, data=0. Arbiter returns to IDLE and accepts the next request.
- CSR file returns excp=1 for r1 write to 0xF11 -> rsp id 1, excp 1. A following r0 request is serviced normally.
- Assert cpu_reset_ni low during WAIT -> all outputs 0 immediately, no response pulse after release, rr_ptr=0 (r0 wins the next tie).
